branch_decoder_unit: RTL and testbench



---
 rtl/branch_decoder_unit.sv | 98 +++++++++
 tb/tb_branch_decoder_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/branch_decoder_unit.sv
// Next-PC source selection for PoliRISC-V, with a registered copy of the selection.
// Define BRANCH_DECODER_UNIT_STATS_EN to add the taken conditional-branch counter.
package branch_decoder_unit_pkg;
   typedef enum logic [2:0] {
      NoBranch   = 3'd0,
      Mret       = 3'd1,
      Sret       = 3'd2,
      Jump       = 3'd3,
      CondBranch = 3'd4
   } branch_t;

   typedef enum logic [2:0] {
      Beq  = 3'd0,
      Bne  = 3'd1,
      Blt  = 3'd2,
      Bge  = 3'd3,
      Bltu = 3'd4,
      Bgeu = 3'd5
   } cond_branch_t;

   typedef enum logic [1:0] {
      PcPlus4             = 2'd0,
      Mepc                = 2'd1,
      Sepc                = 2'd2,
      PcOrReadDataPlusImm = 2'd3
   } pc_src_t;
endpackage

module branch_decoder_unit
   import branch_decoder_unit_pkg::*;
#(
   parameter int unsigned Width = 64
) (
   input  logic               clock,
   input  logic               reset,
   input  branch_t            branch_type,
   input  cond_branch_t       cond_branch_type,
   input  logic [Width-1:0]   read_data_1,
   input  logic [Width-1:0]   read_data_2,
   output pc_src_t            pc_src,
   output pc_src_t            pc_src_q,
   output logic [31:0]        taken_count
);

   logic cond_taken;

   always_comb begin
      cond_taken = 1'b0;
      case (cond_branch_type)
         Beq:     cond_taken = (read_data_1 == read_data_2);
         Bne:     cond_taken = (read_data_1 != read_data_2);
         Blt:     cond_taken = ($signed(read_data_1) <  $signed(read_data_2));
         Bge:     cond_taken = ($signed(read_data_1) >= $signed(read_data_2));
         Bltu:    cond_taken = (read_data_1 <  read_data_2);
         Bgeu:    cond_taken = (read_data_1 >= read_data_2);
         default: cond_taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_src = PcPlus4;
      case (branch_type)
         NoBranch:   pc_src = PcPlus4;
         Mret:       pc_src = Mepc;
         Sret:       pc_src = Sepc;
         Jump:       pc_src = PcOrReadDataPlusImm;
         CondBranch: pc_src = cond_taken ? PcOrReadDataPlusImm : PcPlus4;
         default:    pc_src = PcPlus4;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) pc_src_q <= PcPlus4;
      else       pc_src_q <= pc_src;
   end

`ifdef BRANCH_DECODER_UNIT_STATS_EN
   logic [31:0] taken_count_q;
   logic [31:0] taken_count_d;

   // Only conditional branches count; jumps also select PcOrReadDataPlusImm.
   always_comb begin
      taken_count_d = taken_count_q;
      if (branch_type == CondBranch && pc_src == PcOrReadDataPlusImm)
         taken_count_d = taken_count_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) taken_count_q <= '0;
      else       taken_count_q <= taken_count_d;
   end

   assign taken_count = taken_count_q;
`else
   assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_decoder_unit.sv
// Self-checking bench for branch_decoder_unit: directed cases plus randomized operands.
module tb_branch_decoder_unit;
   import branch_decoder_unit_pkg::*;

`ifdef BRANCH_DECODER_UNIT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   branch_t      branch_type = NoBranch;
   cond_branch_t cond_branch_type = Beq;
   logic [63:0]  read_data_1 = '0;
   logic [63:0]  read_data_2 = '0;
   pc_src_t      pc_src;
   pc_src_t      pc_src_q;
   logic [31:0]  taken_count;

   int unsigned  n_checks = 0;
   int unsigned  n_errors = 0;
   int unsigned  exp_cnt  = 0;

   branch_decoder_unit #(.Width(64)) dut (
      .clock            (clock),
      .reset            (reset),
      .branch_type      (branch_type),
      .cond_branch_type (cond_branch_type),
      .read_data_1      (read_data_1),
      .read_data_2      (read_data_2),
      .pc_src           (pc_src),
      .pc_src_q         (pc_src_q),
      .taken_count      (taken_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: RISC-V branch semantics evaluated on 64-bit integers.
   function automatic pc_src_t ref_pc(input logic [2:0] bt, input logic [2:0] ct,
                                      input logic [63:0] a, input logic [63:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      bit              take;
      sa = a; sb = b; ua = a; ub = b;
      case (bt)
         3'd0: return PcPlus4;
         3'd1: return Mepc;
         3'd2: return Sepc;
         3'd3: return PcOrReadDataPlusImm;
         3'd4: begin
            case (ct)
               3'd0: take = (ua == ub);
               3'd1: take = (ua != ub);
               3'd2: take = (sa <  sb);
               3'd3: take = (sa >= sb);
               3'd4: take = (ua <  ub);
               3'd5: take = (ua >= ub);
               default: take = 1'b0;
            endcase
            return take ? PcOrReadDataPlusImm : PcPlus4;
         end
         default: return PcPlus4;
      endcase
   endfunction

   task automatic apply(input string tag, input logic rst, input logic [2:0] bt,
                        input logic [2:0] ct, input logic [63:0] a, input logic [63:0] b);
      pc_src_t e;
      @(negedge clock);
      reset            = rst;
      branch_type      = branch_t'(bt);
      cond_branch_type = cond_branch_t'(ct);
      read_data_1      = a;
      read_data_2      = b;
      #1;
      e = ref_pc(bt, ct, a, b);
      check({tag, ":pc"}, 32'(pc_src), 32'(e));
      @(posedge clock);
      if (rst) exp_cnt = 0;
      else if (bt == 3'd4 && e == PcOrReadDataPlusImm) exp_cnt++;
      #1;
      check({tag, ":q"}, 32'(pc_src_q), rst ? 32'(PcPlus4) : 32'(e));
      check({tag, ":cnt"}, taken_count, STATS ? exp_cnt : 32'd0);
   endtask

   initial begin
      logic [63:0] a, b;

      // Reset state, and reset must not disturb the combinational output.
      apply("rst0", 1'b1, 3'd3, 3'd0, 64'd0, 64'd0);
      apply("rst1", 1'b1, 3'd1, 3'd0, 64'd0, 64'd0);

      // Non-conditional classes; operands must be irrelevant.
      for (int unsigned bt = 0; bt < 4; bt++)
         apply("bclass", 1'b0, 3'(bt), 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});

      // Out-of-range encodings.
      for (int unsigned bt = 5; bt < 8; bt++)
         apply("bad_bt", 1'b0, 3'(bt), 3'd0, 64'd7, 64'd7);
      apply("bad_ct6", 1'b0, 3'd4, 3'd6, 64'd7, 64'd7);
      apply("bad_ct7", 1'b0, 3'd4, 3'd7, 64'd1, 64'd9);

      // Directed conditional cases.
      apply("beq_eq",  1'b0, 3'd4, 3'd0, 64'h1234, 64'h1234);
      apply("beq_ne",  1'b0, 3'd4, 3'd0, 64'h1234, 64'h1235);
      apply("bne_eq",  1'b0, 3'd4, 3'd1, 64'h1234, 64'h1234);
      apply("bne_ne",  1'b0, 3'd4, 3'd1, 64'h1234, 64'h1235);
      apply("blt_m1",  1'b0, 3'd4, 3'd2, '1, 64'd1);
      apply("bge_m1",  1'b0, 3'd4, 3'd3, '1, 64'd1);
      apply("bge_eq",  1'b0, 3'd4, 3'd3, 64'd5, 64'd5);
      apply("bltu_m1", 1'b0, 3'd4, 3'd4, '1, 64'd1);
      apply("bgeu_m1", 1'b0, 3'd4, 3'd5, '1, 64'd1);
      apply("bltu_hi", 1'b0, 3'd4, 3'd4, 64'd0, 64'h8000_0000_0000_0000);

      // Randomized: (a,b), (b,a) and (a,a) give both outcomes for every kind.
      for (int unsigned ct = 0; ct < 6; ct++) begin
         for (int unsigned i = 0; i < 20; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) b = a + 64'd1;
            if (i % 4 == 2) b = a ^ 64'h8000_0000_0000_0000;
            if (a == b) b = ~a;
            apply("rnd_ab", 1'b0, 3'd4, 3'(ct), a, b);
            apply("rnd_ba", 1'b0, 3'd4, 3'(ct), b, a);
            apply("rnd_aa", 1'b0, 3'd4, 3'(ct), a, a);
         end
      end

      // Counter sequence: 3 taken Beq, a Jump, 2 not-taken Bne.
      apply("seq_rst", 1'b1, 3'd0, 3'd0, 64'd0, 64'd0);
      for (int unsigned i = 0; i < 3; i++)
         apply("seq_beq", 1'b0, 3'd4, 3'd0, 64'd42, 64'd42);
      apply("seq_jmp", 1'b0, 3'd3, 3'd0, 64'd0, 64'd0);
      for (int unsigned i = 0; i < 2; i++)
         apply("seq_bne", 1'b0, 3'd4, 3'd1, 64'd9, 64'd9);
      check("seq_total", taken_count, STATS ? 32'd3 : 32'd0);
      // Reset wins over a simultaneous taken branch.
      apply("seq_clr", 1'b1, 3'd4, 3'd0, 64'd1, 64'd1);
      check("seq_zero", taken_count, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
